// File: rtl/writeback_stage.sv
// Registered writeback stage: result select, variable-latency load handshake,
// load extraction with sign/zero extension, flush draining and retirement count.
module writeback_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int OFF_W      = $clog2(DATA_WIDTH / 8),
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  iClk,
    input  logic                  iRst,
    input  logic                  iValid,
    output logic                  oReady,
    input  logic                  iFlush,
    input  logic [2:0]            iResultSrc,
    input  logic [2:0]            iLoadType,
    input  logic [OFF_W-1:0]      iByteOffset,
    input  logic [DATA_WIDTH-1:0] iAluResult,
    input  logic [DATA_WIDTH-1:0] iPC,
    input  logic [DATA_WIDTH-1:0] iUpperImm,
    input  logic [4:0]            iRd,
    input  logic                  iRegWrite,
    input  logic                  iMemRspValid,
    input  logic [DATA_WIDTH-1:0] iMemRspData,
    output logic                  oWbValid,
    output logic                  oRegWrite,
    output logic [4:0]            oRd,
    output logic [DATA_WIDTH-1:0] oRegDataIn,
    output logic                  oLoadFault,
    output logic [CNT_WIDTH-1:0]  oRetireCount
);

    typedef enum logic [1:0] {IDLE, WAIT_MEM, DRAIN} state_t;

    state_t                  state;
    logic [2:0]              ld_type;
    logic [OFF_W-1:0]        ld_off;
    logic [4:0]              ld_rd;
    logic                    ld_we;
    logic                    accept;
    logic                    is_load;
    logic                    load_ok;
    logic [DATA_WIDTH-1:0]   sel_result;

    function automatic logic load_legal(input logic [2:0] lt);
        logic ok;
        case (lt)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ok = 1'b1;
            3'b011, 3'b110:                         ok = (DATA_WIDTH == 64);
            default:                                ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic load_aligned(input logic [2:0] lt, input logic [OFF_W-1:0] off);
        logic ok;
        case (lt[1:0])
            2'b01:   ok = (off[0] == 1'b0);
            2'b10:   ok = (off[1:0] == 2'b00);
            2'b11:   ok = (off == '0);
            default: ok = 1'b1;
        endcase
        return ok;
    endfunction

    // Shift the addressed lane down to bit 0, then extend to the full width.
    function automatic logic [DATA_WIDTH-1:0] extract_load(input logic [DATA_WIDTH-1:0] word,
                                                         input logic [2:0] lt,
                                                         input logic [OFF_W-1:0] off);
        logic [DATA_WIDTH-1:0] s;
        logic [DATA_WIDTH-1:0] r;
        s = word >> {off, 3'b000};
        case (lt[1:0])
            2'b00: begin
                if (lt[2]) r = DATA_WIDTH'(s[7:0]);
                else       r = DATA_WIDTH'($signed(s[7:0]));
            end
            2'b01: begin
                if (lt[2]) r = DATA_WIDTH'(s[15:0]);
                else       r = DATA_WIDTH'($signed(s[15:0]));
            end
            2'b10: begin
                if (lt[2]) r = DATA_WIDTH'(s[31:0]);
                else       r = DATA_WIDTH'($signed(s[31:0]));
            end
            default: r = s;
        endcase
        return r;
    endfunction

    assign oReady = (state == IDLE);

    always_comb begin
        accept  = iValid && oReady && !iFlush;
        is_load = (iResultSrc == 3'b001);
        load_ok = load_legal(iLoadType) && load_aligned(iLoadType, iByteOffset);
        case (iResultSrc)
            3'b010:  sel_result = iPC + DATA_WIDTH'(4);
            3'b011:  sel_result = iUpperImm;
            3'b100:  sel_result = iPC + iUpperImm;
            default: sel_result = iAluResult;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state        <= IDLE;
            oWbValid     <= 1'b0;
            oRegWrite    <= 1'b0;
            oRd          <= '0;
            oRegDataIn   <= '0;
            oLoadFault   <= 1'b0;
            oRetireCount <= '0;
        end else begin
            oWbValid   <= 1'b0;
            oRegWrite  <= 1'b0;
            oLoadFault <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (is_load && load_ok) begin
                            ld_type <= iLoadType;
                            ld_off  <= iByteOffset;
                            ld_rd   <= iRd;
                            ld_we   <= iRegWrite;
                            state   <= WAIT_MEM;
                        end else begin
                            oWbValid     <= 1'b1;
                            oRd          <= iRd;
                            oRetireCount <= oRetireCount + CNT_WIDTH'(1);
                            // A faulting load retires without touching the data register.
                            if (is_load) begin
                                oLoadFault <= 1'b1;
                            end else begin
                                oRegWrite  <= iRegWrite && (iRd != 5'd0);
                                oRegDataIn <= sel_result;
                            end
                        end
                    end
                end
                WAIT_MEM: begin
                    if (iFlush) begin
                        state <= iMemRspValid ? IDLE : DRAIN;
                    end else if (iMemRspValid) begin
                        oWbValid     <= 1'b1;
                        oRd          <= ld_rd;
                        oRegWrite    <= ld_we && (ld_rd != 5'd0);
                        oRegDataIn   <= extract_load(iMemRspData, ld_type, ld_off);
                        oRetireCount <= oRetireCount + CNT_WIDTH'(1);
                        state        <= IDLE;
                    end
                end
                DRAIN: begin
                    if (iMemRspValid) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage (DATA_WIDTH=32): directed scenarios
// plus randomized traffic checked against a behavioural model.
module tb_writeback_stage;

    localparam int DW = 32;
    localparam int OW = 2;
    localparam int CW = 32;

    logic          clk;
    logic          rst;
    logic          valid;
    logic          ready;
    logic          flush;
    logic [2:0]    src;
    logic [2:0]    lt;
    logic [OW-1:0] off;
    logic [DW-1:0] alu;
    logic [DW-1:0] pc;
    logic [DW-1:0] uimm;
    logic [4:0]    rd;
    logic          rw;
    logic          rsp_v;
    logic [DW-1:0] rsp_d;
    logic          wb_v;
    logic          wr;
    logic [4:0]    ord;
    logic [DW-1:0] odata;
    logic          fault;
    logic [CW-1:0] cnt;

    int            n_cmp;
    int            n_err;
    logic [CW-1:0] exp_cnt;

    writeback_stage #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .iClk(clk), .iRst(rst), .iValid(valid), .oReady(ready), .iFlush(flush),
        .iResultSrc(src), .iLoadType(lt), .iByteOffset(off), .iAluResult(alu),
        .iPC(pc), .iUpperImm(uimm), .iRd(rd), .iRegWrite(rw),
        .iMemRspValid(rsp_v), .iMemRspData(rsp_d), .oWbValid(wb_v),
        .oRegWrite(wr), .oRd(ord), .oRegDataIn(odata), .oLoadFault(fault),
        .oRetireCount(cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference model: value written for a non-load instruction.
    function automatic logic [DW-1:0] m_result(input logic [2:0] s, input logic [DW-1:0] a,
                                               input logic [DW-1:0] p, input logic [DW-1:0] im);
        longint unsigned modv;
        modv = 64'd1 << DW;
        case (s)
            3'd2:    return DW'((longint'(p) + 4) % modv);
            3'd3:    return im;
            3'd4:    return DW'((longint'(p) + longint'(im)) % modv);
            default: return a;
        endcase
    endfunction

    // Reference model: is the load legal and aligned for a 32-bit core.
    function automatic bit m_legal(input logic [2:0] t, input logic [OW-1:0] o);
        int sz;
        case (t)
            3'd0, 3'd4: sz = 1;
            3'd1, 3'd5: sz = 2;
            3'd2:       sz = 4;
            default:    return 1'b0;
        endcase
        return (int'(o) % sz) == 0;
    endfunction

    // Reference model: extracted and extended load value.
    function automatic logic [DW-1:0] m_load(input logic [DW-1:0] w, input logic [2:0] t,
                                             input logic [OW-1:0] o);
        int     bits;
        longint v;
        longint span;
        bits = 8 * (1 << t[1:0]);
        span = longint'(1) << bits;
        v = (longint'(w) >> (8 * int'(o))) % span;
        if (t[2] == 1'b0 && v >= span / 2) v = v - span;
        return v[DW-1:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        valid = 1'b0;
        flush = 1'b0;
        rsp_v = 1'b0;
    endtask

    task automatic drive_op(input logic [2:0] s, input logic [DW-1:0] a, input logic [DW-1:0] p,
                            input logic [DW-1:0] im, input logic [4:0] r, input logic w);
        valid = 1'b1; src = s; alu = a; pc = p; uimm = im; rd = r; rw = w;
    endtask

    task automatic drive_load(input logic [2:0] t, input logic [OW-1:0] o,
                              input logic [4:0] r, input logic w);
        valid = 1'b1; src = 3'b001; lt = t; off = o; rd = r; rw = w;
        alu = DW'($urandom); pc = DW'($urandom); uimm = DW'($urandom);
    endtask

    task automatic test_reset();
        quiet();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        exp_cnt = '0;
        n_cmp++;
        if ({ready, wb_v, wr, fault} !== 4'b1000) begin
            n_err++;
            $display("FAIL reset_ctrl: ready/wb/wr/fault=%b want 1000", {ready, wb_v, wr, fault});
        end
        n_cmp++;
        if ({ord, odata, cnt} !== {5'd0, {DW{1'b0}}, {CW{1'b0}}}) begin
            n_err++;
            $display("FAIL reset_data: rd=%0d data=%h cnt=%0d want zeros", ord, odata, cnt);
        end
    endtask

    task automatic test_alu();
        drive_op(3'b000, 32'h1234, 32'h0, 32'h0, 5'd5, 1'b1);
        tick();
        quiet();
        exp_cnt++;
        n_cmp++;
        if ({wb_v, wr, ord, odata, cnt} !== {1'b1, 1'b1, 5'd5, 32'h1234, exp_cnt}) begin
            n_err++;
            $display("FAIL alu: wb=%b wr=%b rd=%0d data=%h cnt=%0d want 1 1 5 1234 %0d",
                     wb_v, wr, ord, odata, cnt, exp_cnt);
        end
        tick();
        n_cmp++;
        if ({wb_v, ord, odata} !== {1'b0, 5'd5, 32'h1234}) begin
            n_err++;
            $display("FAIL alu_hold: wb=%b rd=%0d data=%h want 0 5 1234", wb_v, ord, odata);
        end
    endtask

    task automatic test_pc_ops();
        drive_op(3'b010, 32'h0, 32'hFFFF_FFFC, 32'h0, 5'd1, 1'b1);
        tick();
        exp_cnt++;
        n_cmp++;
        if ({wb_v, odata} !== {1'b1, 32'h0000_0000}) begin
            n_err++;
            $display("FAIL pc4_wrap: wb=%b data=%h want 1 00000000", wb_v, odata);
        end
        drive_op(3'b100, 32'h0, 32'h100, 32'h2000, 5'd2, 1'b1);
        tick();
        exp_cnt++;
        n_cmp++;
        if ({wb_v, odata} !== {1'b1, 32'h0000_2100}) begin
            n_err++;
            $display("FAIL pc_imm: wb=%b data=%h want 1 00002100", wb_v, odata);
        end
        drive_op(3'b111, 32'hCAFE_0001, 32'h100, 32'h2000, 5'd3, 1'b1);
        tick();
        quiet();
        exp_cnt++;
        n_cmp++;
        if ({wb_v, odata, cnt} !== {1'b1, 32'hCAFE_0001, exp_cnt}) begin
            n_err++;
            $display("FAIL src_default: wb=%b data=%h cnt=%0d want 1 cafe0001 %0d",
                     wb_v, odata, cnt, exp_cnt);
        end
    endtask

    task automatic test_load_wait(input logic [2:0] t, input logic [DW-1:0] want);
        int low;
        drive_load(t, 2'd3, 5'd7, 1'b1);
        tick();
        quiet();
        low = 0;
        for (int i = 0; i < 4; i++) begin
            if (!ready && !wb_v) low++;
            if (i == 3) begin
                rsp_v = 1'b1;
                rsp_d = 32'h80AB_CDEF;
            end
            tick();
            rsp_v = 1'b0;
        end
        exp_cnt++;
        n_cmp++;
        if (low !== 4) begin
            n_err++;
            $display("FAIL load_ready_low: cycles=%0d want 4", low);
        end
        n_cmp++;
        if ({ready, wb_v, wr, fault, ord, odata, cnt} !== {4'b1110, 5'd7, want, exp_cnt}) begin
            n_err++;
            $display("FAIL load_lt%0d: rdy=%b wb=%b wr=%b flt=%b rd=%0d data=%h cnt=%0d want 1 1 1 0 7 %h %0d",
                     t, ready, wb_v, wr, fault, ord, odata, cnt, want, exp_cnt);
        end
    endtask

    task automatic test_fault(input logic [2:0] t, input logic [OW-1:0] o, input logic [4:0] r);
        drive_load(t, o, r, 1'b1);
        tick();
        quiet();
        exp_cnt++;
        n_cmp++;
        if ({ready, wb_v, wr, fault, ord, cnt} !== {4'b1101, r, exp_cnt}) begin
            n_err++;
            $display("FAIL fault_lt%0d_off%0d: rdy=%b wb=%b wr=%b flt=%b rd=%0d cnt=%0d want 1 1 0 1 %0d %0d",
                     t, o, ready, wb_v, wr, fault, ord, cnt, r, exp_cnt);
        end
    endtask

    task automatic test_flush();
        int pulses;
        int low;
        // Flush with a pending load, response two cycles later.
        drive_load(3'b010, 2'd0, 5'd9, 1'b1);
        tick();
        quiet();
        pulses = 0;
        low = 0;
        flush = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (wb_v) pulses++;
            if (!ready) low++;
            if (i == 2) begin
                rsp_v = 1'b1;
                rsp_d = 32'h1111_2222;
            end
            tick();
            flush = 1'b0;
            rsp_v = 1'b0;
        end
        n_cmp++;
        if ({pulses, low} !== {32'd0, 32'd3}) begin
            n_err++;
            $display("FAIL flush_drain: pulses=%0d low_cycles=%0d want 0 3", pulses, low);
        end
        n_cmp++;
        if ({ready, wb_v, cnt} !== {1'b1, 1'b0, exp_cnt}) begin
            n_err++;
            $display("FAIL flush_after: rdy=%b wb=%b cnt=%0d want 1 0 %0d", ready, wb_v, cnt, exp_cnt);
        end
        // Flush coinciding with the response goes straight back to IDLE.
        drive_load(3'b000, 2'd1, 5'd9, 1'b1);
        tick();
        quiet();
        flush = 1'b1;
        rsp_v = 1'b1;
        tick();
        quiet();
        n_cmp++;
        if ({ready, wb_v, cnt} !== {1'b1, 1'b0, exp_cnt}) begin
            n_err++;
            $display("FAIL flush_same_rsp: rdy=%b wb=%b cnt=%0d want 1 0 %0d", ready, wb_v, cnt, exp_cnt);
        end
        // Flush in IDLE drops the incoming instruction.
        drive_op(3'b000, 32'h5555, 32'h0, 32'h0, 5'd4, 1'b1);
        flush = 1'b1;
        tick();
        quiet();
        n_cmp++;
        if ({ready, wb_v, cnt} !== {1'b1, 1'b0, exp_cnt}) begin
            n_err++;
            $display("FAIL flush_idle: rdy=%b wb=%b cnt=%0d want 1 0 %0d", ready, wb_v, cnt, exp_cnt);
        end
    endtask

    task automatic test_rd0();
        drive_op(3'b000, 32'h7777, 32'h0, 32'h0, 5'd0, 1'b1);
        tick();
        quiet();
        exp_cnt++;
        n_cmp++;
        if ({wb_v, wr, cnt} !== {1'b1, 1'b0, exp_cnt}) begin
            n_err++;
            $display("FAIL rd0: wb=%b wr=%b cnt=%0d want 1 0 %0d", wb_v, wr, cnt, exp_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] vals [4];
        int            good;
        good = 0;
        for (int i = 0; i < 4; i++) vals[i] = DW'($urandom);
        for (int i = 0; i < 4; i++) begin
            drive_op(3'b000, vals[i], 32'h0, 32'h0, 5'(10 + i), 1'b1);
            tick();
            exp_cnt++;
            if (wb_v && wr && ord == 5'(10 + i) && odata == vals[i] && cnt == exp_cnt) good++;
        end
        quiet();
        n_cmp++;
        if (good !== 4) begin
            n_err++;
            $display("FAIL back_to_back: good_pulses=%0d want 4", good);
        end
    endtask

    task automatic test_reset_mid();
        drive_load(3'b010, 2'd0, 5'd6, 1'b1);
        tick();
        quiet();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_cnt = '0;
        rsp_v = 1'b1;
        rsp_d = 32'hDEAD_BEEF;
        tick();
        quiet();
        n_cmp++;
        if ({ready, wb_v, cnt} !== {1'b1, 1'b0, exp_cnt}) begin
            n_err++;
            $display("FAIL reset_mid: rdy=%b wb=%b cnt=%0d want 1 0 0", ready, wb_v, cnt);
        end
    endtask

    task automatic test_random();
        logic [2:0]    s;
        logic [2:0]    t;
        logic [OW-1:0] o;
        logic [4:0]    r;
        logic          w;
        logic [DW-1:0] d;
        logic [DW-1:0] want;
        int            waits;
        int            bad;
        for (int n = 0; n < 300; n++) begin
            r = 5'($urandom);
            w = 1'($urandom);
            bad = 0;
            if ($urandom_range(0, 1) == 0) begin
                s = 3'($urandom);
                if (s == 3'b001) s = 3'b000;
                drive_op(s, DW'($urandom), DW'($urandom), DW'($urandom), r, w);
                want = m_result(s, alu, pc, uimm);
                tick();
                quiet();
                exp_cnt++;
                n_cmp++;
                if ({wb_v, wr, fault, ord, odata, cnt} !==
                    {1'b1, w && (r != 5'd0), 1'b0, r, want, exp_cnt}) begin
                    n_err++;
                    $display("FAIL rand_op src=%0d: wb=%b wr=%b flt=%b rd=%0d data=%h cnt=%0d want data=%h rd=%0d cnt=%0d",
                             s, wb_v, wr, fault, ord, odata, cnt, want, r, exp_cnt);
                end
            end else begin
                t = 3'($urandom);
                o = OW'($urandom);
                d = DW'($urandom);
                drive_load(t, o, r, w);
                tick();
                quiet();
                if (!m_legal(t, o)) begin
                    exp_cnt++;
                    n_cmp++;
                    if ({ready, wb_v, wr, fault, ord, cnt} !== {4'b1101, r, exp_cnt}) begin
                        n_err++;
                        $display("FAIL rand_fault lt=%0d off=%0d: rdy=%b wb=%b wr=%b flt=%b rd=%0d cnt=%0d",
                                 t, o, ready, wb_v, wr, fault, ord, cnt);
                    end
                end else begin
                    waits = $urandom_range(0, 3);
                    for (int i = 0; i < waits; i++) begin
                        if (ready || wb_v) bad++;
                        rsp_d = DW'($urandom);
                        tick();
                    end
                    if (ready || wb_v) bad++;
                    rsp_v = 1'b1;
                    rsp_d = d;
                    tick();
                    quiet();
                    want = m_load(d, t, o);
                    exp_cnt++;
                    n_cmp++;
                    if (bad != 0 || {ready, wb_v, wr, fault, ord, odata, cnt} !==
                        {2'b11, w && (r != 5'd0), 1'b0, r, want, exp_cnt}) begin
                        n_err++;
                        $display("FAIL rand_load lt=%0d off=%0d word=%h: stall_errs=%0d rdy=%b wb=%b wr=%b flt=%b rd=%0d data=%h cnt=%0d want data=%h rd=%0d cnt=%0d",
                                 t, o, d, bad, ready, wb_v, wr, fault, ord, odata, cnt, want, r, exp_cnt);
                    end
                end
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        exp_cnt = '0;
        rst = 1'b1;
        src = 3'b000; lt = 3'b000; off = '0; alu = '0; pc = '0; uimm = '0;
        rd = 5'd0; rw = 1'b0; rsp_d = '0;
        quiet();
        test_reset();
        test_alu();
        test_pc_ops();
        test_load_wait(3'b000, 32'hFFFF_FF80);
        test_load_wait(3'b100, 32'h0000_0080);
        test_fault(3'b001, 2'd1, 5'd8);
        test_fault(3'b011, 2'd0, 5'd11);
        test_fault(3'b110, 2'd0, 5'd12);
        test_fault(3'b010, 2'd2, 5'd13);
        test_flush();
        test_rd0();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
